// File: rtl/systolic_feeder_3by3.sv
//------------------------------------------------------------------------------
// Module  : systolic_feeder_3by3
// Brief   : Latches a 4x4 matrix and streams three skewed rows into a 3x3
//           systolic array. Optional macro FEEDER_PIPE_OUT_EN adds an output
//           register stage on left1/2/3, valid and done.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module systolic_feeder_3by3 #(
  parameter int DW   = 8,
  parameter int NCYC = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [16*DW-1:0] a_flat,
  output logic [DW-1:0]    left1,
  output logic [DW-1:0]    left2,
  output logic [DW-1:0]    left3,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_STREAM = 1'b1
  } state_t;

  localparam logic [3:0] C_TLAST = 4'(NCYC - 1);

  state_t             r_state, w_state_nxt;
  logic [3:0]         r_t, w_t_nxt;
  logic [16*DW-1:0]   r_mat, w_mat_nxt;
  logic               w_done_nxt;
  logic               w_stream_nxt;
  logic [DW-1:0]      w_left_nxt [3];
  logic [DW-1:0]      r_left [3];
  logic               r_valid;
  logic               r_busy;
  logic               r_done;

  // Element j of row stream k: row k+1 reversed, then row k reversed.
  function automatic logic [DW-1:0] seq_val(input logic [16*DW-1:0] m,
                                            input int k, input int j);
    int row;
    int col;
    row = (j < 4) ? k + 1 : k;
    col = (j < 4) ? 4 - j : 8 - j;
    return m[((row - 1) * 4 + col - 1) * DW +: DW];
  endfunction

  always_comb begin
    w_state_nxt = r_state;
    w_t_nxt     = r_t;
    w_mat_nxt   = r_mat;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_STREAM;
          w_t_nxt     = '0;
          w_mat_nxt   = a_flat;
        end
      end
      S_STREAM: begin
        if (r_t == C_TLAST) begin
          w_done_nxt = 1'b1;
          w_t_nxt    = '0;
          // A start on the last cycle chains straight into the next frame.
          if (start) w_mat_nxt = a_flat;
          else       w_state_nxt = S_IDLE;
        end else begin
          w_t_nxt = r_t + 4'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_stream_nxt = (w_state_nxt == S_STREAM);

  // Outputs are computed from next-state values so they register in step with t.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      w_left_nxt[k] = '0;
      if (w_stream_nxt && int'(w_t_nxt) >= k && int'(w_t_nxt) <= k + 7)
        w_left_nxt[k] = seq_val(w_mat_nxt, k + 1, int'(w_t_nxt) - k);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_t     <= '0;
      r_mat   <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      for (int k = 0; k < 3; k++) r_left[k] <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_t     <= w_t_nxt;
      r_mat   <= w_mat_nxt;
      r_valid <= w_stream_nxt;
      r_busy  <= w_stream_nxt;
      r_done  <= w_done_nxt;
      for (int k = 0; k < 3; k++) r_left[k] <= w_left_nxt[k];
    end
  end

`ifdef FEEDER_PIPE_OUT_EN
  logic [DW-1:0] r_pipe_left [3];
  logic          r_pipe_valid;
  logic          r_pipe_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pipe_valid <= 1'b0;
      r_pipe_done  <= 1'b0;
      for (int k = 0; k < 3; k++) r_pipe_left[k] <= '0;
    end else begin
      r_pipe_valid <= r_valid;
      r_pipe_done  <= r_done;
      for (int k = 0; k < 3; k++) r_pipe_left[k] <= r_left[k];
    end
  end

  assign left1 = r_pipe_left[0];
  assign left2 = r_pipe_left[1];
  assign left3 = r_pipe_left[2];
  assign valid = r_pipe_valid;
  assign done  = r_pipe_done;
`else
  assign left1 = r_left[0];
  assign left2 = r_left[1];
  assign left3 = r_left[2];
  assign valid = r_valid;
  assign done  = r_done;
`endif

  assign busy = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_systolic_feeder_3by3.sv
//------------------------------------------------------------------------------
// Module  : tb_systolic_feeder_3by3
// Brief   : Self-checking bench for systolic_feeder_3by3 against a frame-level
//           reference model. Honors FEEDER_PIPE_OUT_EN.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_systolic_feeder_3by3;

  localparam int DW = 8;
`ifdef FEEDER_PIPE_OUT_EN
  localparam bit PIPE = 1'b1;
`else
  localparam bit PIPE = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [16*DW-1:0] a_flat;
  logic [DW-1:0]    left1, left2, left3;
  logic             valid, busy, done;

  systolic_feeder_3by3 #(.DW(DW), .NCYC(10)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a_flat(a_flat),
    .left1 (left1),
    .left2 (left2),
    .left3 (left3),
    .valid (valid),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: mt is the stream position (-1 when idle).
  int               mt = -1;
  logic [16*DW-1:0] mflat = '0;
  logic             mdone = 1'b0;
  logic [3*DW+1:0]  mprev = '0;

  function automatic logic [DW-1:0] elem(input logic [16*DW-1:0] m, input int r, input int c);
    return m[((r - 1) * 4 + c - 1) * DW +: DW];
  endfunction

  function automatic logic [DW-1:0] exp_left(input int k);
    int j;
    j = mt - (k - 1);
    if (mt < 0 || j < 0 || j > 7) return '0;
    if (j < 4) return elem(mflat, k + 1, 4 - j);
    return elem(mflat, k, 8 - j);
  endfunction

  function automatic logic [3*DW+1:0] exp_stage();
    return {exp_left(1), exp_left(2), exp_left(3), (mt >= 0), mdone};
  endfunction

  // Expected {left1,left2,left3,valid,busy,done}
  function automatic logic [3*DW+2:0] expected();
    logic [3*DW+1:0] s;
    s = PIPE ? mprev : exp_stage();
    return {s[3*DW+1:1], (mt >= 0), s[0]};
  endfunction

  function automatic logic [16*DW-1:0] seq_mat(input int base);
    logic [16*DW-1:0] m;
    for (int i = 0; i < 16; i++) m[i*DW +: DW] = DW'(base + i);
    return m;
  endfunction

  function automatic logic [16*DW-1:0] rand_mat(input int maxv);
    logic [16*DW-1:0] m;
    for (int i = 0; i < 16; i++) m[i*DW +: DW] = DW'($urandom_range(maxv, 0));
    return m;
  endfunction

  task automatic step();
    @(posedge clk);
    mprev = rst ? '0 : exp_stage();
    if (rst) begin
      mt = -1; mflat = '0; mdone = 1'b0;
    end else begin
      mdone = (mt == 9);
      if (mt < 0 || mt == 9) begin
        if (start) begin mt = 0; mflat = a_flat; end
        else mt = -1;
      end else begin
        mt = mt + 1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a_flat = '1;
    step();
    n_checks++;
    if ({left1, left2, left3, valid, busy, done} !== '0) begin
      n_fail++;
      $display("FAIL reset got=%h exp=0", {left1, left2, left3, valid, busy, done});
    end
    rst = 1'b0;
    step();
    n_checks++;
    if ({left1, left2, left3, valid, busy, done} !== expected()) begin
      n_fail++;
      $display("FAIL reset_idle got=%h exp=%h", {left1, left2, left3, valid, busy, done}, expected());
    end
  endtask

  task automatic test_basic_frame();
    a_flat = seq_mat(1); start = 1'b1;
    step();
    start = 1'b0; a_flat = '0;
    for (int c = 0; c < 12; c++) begin
      n_checks++;
      if ({left1, left2, left3, valid, busy, done} !== expected()) begin
        n_fail++;
        $display("FAIL basic_frame c=%0d got=%h exp=%h", c, {left1, left2, left3, valid, busy, done}, expected());
      end
      if (c == PIPE) begin
        n_checks++;
        if (left1 !== 8'd8) begin
          n_fail++;
          $display("FAIL basic_first_left1 got=%0d exp=8", left1);
        end
      end
      step();
    end
  endtask

  task automatic test_ignored_start();
    logic [16*DW-1:0] m;
    m = rand_mat(254);
    a_flat = m; start = 1'b1;
    step();
    for (int c = 0; c < 12; c++) begin
      n_checks++;
      if ({left1, left2, left3, valid, busy, done} !== expected()) begin
        n_fail++;
        $display("FAIL ignored_start c=%0d got=%h exp=%h", c, {left1, left2, left3, valid, busy, done}, expected());
      end
      start  = (c == 4);
      a_flat = (c == 4) ? '1 : m;
      step();
    end
    start = 1'b0;
  endtask

  task automatic test_back_to_back();
    a_flat = rand_mat(255); start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 22; c++) begin
      n_checks++;
      if ({left1, left2, left3, valid, busy, done} !== expected()) begin
        n_fail++;
        $display("FAIL back_to_back c=%0d got=%h exp=%h", c, {left1, left2, left3, valid, busy, done}, expected());
      end
      if (c == 10 + PIPE) begin
        n_checks++;
        if (left1 !== 8'd24 || done !== 1'b1 || valid !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_restart left1=%0d done=%b valid=%b exp 24 1 1", left1, done, valid);
        end
      end
      start  = (c == 9);
      a_flat = (c == 9) ? seq_mat(17) : rand_mat(255);
      step();
    end
    start = 1'b0;
  endtask

  task automatic test_mid_reset();
    a_flat = rand_mat(255); start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 26; c++) begin
      n_checks++;
      if ({left1, left2, left3, valid, busy, done} !== expected()) begin
        n_fail++;
        $display("FAIL mid_reset c=%0d got=%h exp=%h", c, {left1, left2, left3, valid, busy, done}, expected());
      end
      if (c == 6) begin
        n_checks++;
        if ({left1, left2, left3, valid, busy, done} !== '0) begin
          n_fail++;
          $display("FAIL mid_reset_clear got=%h exp=0", {left1, left2, left3, valid, busy, done});
        end
      end
      rst    = (c == 5);
      start  = (c == 9);
      a_flat = rand_mat(255);
      step();
    end
    rst = 1'b0; start = 1'b0;
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 8; f++) begin
      for (int c = 0; c < 16; c++) begin
        start  = ($urandom_range(3, 0) == 0);
        a_flat = rand_mat(255);
        step();
        n_checks++;
        if ({left1, left2, left3, valid, busy, done} !== expected()) begin
          n_fail++;
          $display("FAIL random f=%0d c=%0d got=%h exp=%h", f, c, {left1, left2, left3, valid, busy, done}, expected());
        end
      end
    end
    start = 1'b0;
    for (int c = 0; c < 13; c++) step();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a_flat = '0;
    step();
    step();
    rst = 1'b0;
    step();
    test_reset();
    test_basic_frame();
    test_ignored_start();
    test_back_to_back();
    test_mid_reset();
    test_random_frames();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
